// File: rtl/aie_pkg.sv
// Shared types for the analog input emulator: per-channel source mode and ramp FSM state.
package aie_pkg;

  typedef enum logic [1:0] {
    MODE_DIG = 2'd0,
    MODE_ANA = 2'd1,
    MODE_PAD = 2'd2
  } aie_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RAMP_UP = 2'd1,
    ST_RAMP_DN = 2'd2,
    ST_RETURN  = 2'd3
  } aie_state_e;

endpackage

// File: rtl/analog_input_emu_if.sv
// Control/value bundle of the analog input emulator; master drives buttons and sources, slave returns values.
interface analog_input_emu_if #(
  parameter int NCH = 2,
  parameter int W   = 8
);

  logic               strobe;
  logic [NCH-1:0]     plus;
  logic [NCH-1:0]     minus;
  logic [2*NCH-1:0]   mode;
  logic [NCH*W-1:0]   ana_in;
  logic [NCH*W-1:0]   value;
  logic [NCH-1:0]     active;

  modport master (
    output strobe, plus, minus, mode, ana_in,
    input  value, active
  );

  modport slave (
    input  strobe, plus, minus, mode, ana_in,
    output value, active
  );

endinterface

// File: rtl/aie_channel.sv
// One emulated control channel: digital ramp FSM with acceleration, or direct analog/paddle tracking.
// Auto-centring of released digital channels is enabled by defining AIE_AUTO_CENTER_EN.
module aie_channel
  import aie_pkg::*;
#(
  parameter int           W            = 8,
  parameter logic [W-1:0] VMIN         = '0,
  parameter logic [W-1:0] VMAX         = {W{1'b1}},
  parameter logic [W-1:0] CENTER       = {1'b1, {(W-1){1'b0}}},
  parameter logic [W-1:0] STEP_MIN     = W'(1),
  parameter logic [W-1:0] STEP_MAX     = W'(8),
  parameter logic [W-1:0] ACCEL_FRAMES = W'(4),
  parameter logic [W-1:0] RET_STEP     = W'(4)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         plus,
  input  logic         minus,
  input  logic [1:0]   mode,
  input  logic [W-1:0] ana_in,
  output logic [W-1:0] value,
  output logic         active
);

`ifdef AIE_AUTO_CENTER_EN
  localparam bit AUTO_CENTER = 1'b1;
`else
  localparam bit AUTO_CENTER = 1'b0;
`endif

  aie_state_e   state_q, state_d;
  logic [W-1:0] value_q, value_d;
  logic [W-1:0] step_q, step_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] cnt_inc, step_acc, ret_val;
  logic         acc_hit;

  function automatic logic [W-1:0] ramp_up(input logic [W-1:0] v, input logic [W-1:0] s);
    logic [W:0] sum;
    sum = {1'b0, v} + {1'b0, s};
    return (sum > {1'b0, VMAX}) ? VMAX : sum[W-1:0];
  endfunction

  function automatic logic [W-1:0] ramp_dn(input logic [W-1:0] v, input logic [W-1:0] s);
    logic [W:0] diff;
    diff = {1'b0, v} - {1'b0, s};
    return (diff[W] || (diff[W-1:0] < VMIN)) ? VMIN : diff[W-1:0];
  endfunction

  function automatic logic [W-1:0] clamp(input logic signed [W+1:0] x);
    if (x < $signed({2'b00, VMIN})) return VMIN;
    if (x > $signed({2'b00, VMAX})) return VMAX;
    return x[W-1:0];
  endfunction

  // Step toward CENTER, landing exactly on it rather than overshooting.
  function automatic logic [W-1:0] toward_center(input logic [W-1:0] v);
    if (v > CENTER) return ((v - CENTER) > RET_STEP) ? (v - RET_STEP) : CENTER;
    return ((CENTER - v) > RET_STEP) ? (v + RET_STEP) : CENTER;
  endfunction

  assign cnt_inc  = cnt_q + W'(1);
  assign acc_hit  = (cnt_inc == ACCEL_FRAMES);
  assign step_acc = (acc_hit && (step_q < STEP_MAX)) ? (step_q + W'(1)) : step_q;
  assign ret_val  = toward_center(value_q);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    value_d = value_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    case (mode)
      MODE_ANA: begin
        value_d = clamp($signed({2'b00, CENTER}) + $signed({{2{ana_in[W-1]}}, ana_in}));
        state_d = ST_IDLE;
        step_d  = STEP_MIN;
        cnt_d   = '0;
      end
      MODE_PAD: begin
        value_d = clamp($signed({2'b00, ana_in}));
        state_d = ST_IDLE;
        step_d  = STEP_MIN;
        cnt_d   = '0;
      end
      default: begin
        if (tick) begin
          if (plus && !minus) begin
            if (state_q == ST_RAMP_UP) begin
              value_d = ramp_up(value_q, step_acc);
              step_d  = step_acc;
              cnt_d   = acc_hit ? '0 : cnt_inc;
            end else begin
              state_d = ST_RAMP_UP;
              value_d = ramp_up(value_q, STEP_MIN);
              step_d  = STEP_MIN;
              cnt_d   = '0;
            end
          end else if (minus && !plus) begin
            if (state_q == ST_RAMP_DN) begin
              value_d = ramp_dn(value_q, step_acc);
              step_d  = step_acc;
              cnt_d   = acc_hit ? '0 : cnt_inc;
            end else begin
              state_d = ST_RAMP_DN;
              value_d = ramp_dn(value_q, STEP_MIN);
              step_d  = STEP_MIN;
              cnt_d   = '0;
            end
          end else begin
            // Released (or both pressed): drift home when auto-centring, otherwise freeze.
            step_d = STEP_MIN;
            cnt_d  = '0;
            if (AUTO_CENTER && (value_q != CENTER)) begin
              value_d = ret_val;
              state_d = (ret_val == CENTER) ? ST_IDLE : ST_RETURN;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= ST_IDLE;
      value_q <= CENTER;
      step_q  <= STEP_MIN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end

  assign value  = value_q;
  assign active = (state_q != ST_IDLE);

endmodule

// File: rtl/analog_input_emu.sv
// Analog input emulator top: frame-strobe edge detect shared by NCH independent channels.
module analog_input_emu
  import aie_pkg::*;
#(
  parameter int           NCH          = 2,
  parameter int           W            = 8,
  parameter logic [W-1:0] VMIN         = '0,
  parameter logic [W-1:0] VMAX         = {W{1'b1}},
  parameter logic [W-1:0] CENTER       = {1'b1, {(W-1){1'b0}}},
  parameter logic [W-1:0] STEP_MIN     = W'(1),
  parameter logic [W-1:0] STEP_MAX     = W'(8),
  parameter logic [W-1:0] ACCEL_FRAMES = W'(4),
  parameter logic [W-1:0] RET_STEP     = W'(4)
) (
  input  logic               clk,
  input  logic               reset,
  analog_input_emu_if.slave  bus
);

  logic             strobe_d;
  logic             tick;
  logic [NCH*W-1:0] value_pk;
  logic [NCH-1:0]   active_pk;

  always_ff @(posedge clk) begin
    if (reset) strobe_d <= 1'b0;
    else       strobe_d <= bus.strobe;
  end

  assign tick = bus.strobe & ~strobe_d;

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    aie_channel #(
      .W            (W),
      .VMIN         (VMIN),
      .VMAX         (VMAX),
      .CENTER       (CENTER),
      .STEP_MIN     (STEP_MIN),
      .STEP_MAX     (STEP_MAX),
      .ACCEL_FRAMES (ACCEL_FRAMES),
      .RET_STEP     (RET_STEP)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .plus   (bus.plus[n]),
      .minus  (bus.minus[n]),
      .mode   (bus.mode[2*n +: 2]),
      .ana_in (bus.ana_in[n*W +: W]),
      .value  (value_pk[n*W +: W]),
      .active (active_pk[n])
    );
  end

  assign bus.value  = value_pk;
  assign bus.active = active_pk;

endmodule

// File: tb/tb_analog_input_emu.sv
// Scoreboard bench for analog_input_emu: directed stimulus queues expectations, a negedge monitor checks them.
module tb_analog_input_emu;
  import aie_pkg::*;

  localparam int NCH = 2;
  localparam int W   = 8;

`ifdef AIE_AUTO_CENTER_EN
  localparam bit AC = 1'b1;
`else
  localparam bit AC = 1'b0;
`endif

  typedef struct {
    int           due;
    int           ch;
    logic [W-1:0] val;
    logic         act;
    string        name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  analog_input_emu_if #(.NCH(NCH), .W(W)) bus ();

  analog_input_emu #(.NCH(NCH), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Monitor: at each negedge, compare every expectation due this cycle.
  always @(negedge clk) begin : mon
    exp_t         e;
    logic [W-1:0] got_v;
    logic         got_a;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e     = sb_q.pop_front();
      got_v = bus.value[e.ch*W +: W];
      got_a = bus.active[e.ch];
      checks++;
      if (e.due != cyc || got_v !== e.val) begin
        errors++;
        $display("FAIL %s ch%0d value: got %0d expected %0d (cycle %0d due %0d)",
                 e.name, e.ch, got_v, e.val, cyc, e.due);
      end
      checks++;
      if (got_a !== e.act) begin
        errors++;
        $display("FAIL %s ch%0d active: got %0b expected %0b", e.name, e.ch, got_a, e.act);
      end
    end
  end

  task automatic sb_push(input int lat, input int ch, input logic [W-1:0] v, input logic a,
                         input string name);
    exp_t e;
    e.due  = cyc + lat;
    e.ch   = ch;
    e.val  = v;
    e.act  = a;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_begin();
    step_clk();
    bus.strobe = 1'b1;
  endtask

  task automatic tick_end();
    step_clk();
    bus.strobe = 1'b0;
  endtask

  task automatic tick();
    tick_begin();
    tick_end();
  endtask

  task automatic tick_exp(input int ch, input logic [W-1:0] v, input logic a, input string name);
    tick_begin();
    sb_push(1, ch, v, a, name);
    tick_end();
  endtask

  task automatic set_src(input int ch, input aie_mode_e m, input logic [W-1:0] ana,
                         input logic [W-1:0] expv, input string name);
    step_clk();
    bus.mode[2*ch +: 2]   = m;
    bus.ana_in[ch*W +: W] = ana;
    sb_push(1, ch, expv, 1'b0, name);
  endtask

  task automatic to_digital(input int ch, input logic [W-1:0] holdv, input string name);
    step_clk();
    bus.mode[2*ch +: 2] = MODE_DIG;
    sb_push(1, ch, holdv, 1'b0, name);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset      = 1'b1;
    bus.strobe = 1'b0;
    bus.plus   = '0;
    bus.minus  = '0;
    bus.mode   = '0;
    bus.ana_in = '0;
    repeat (3) step_clk();
    reset = 1'b0;
    sb_push(0, 0, 8'd128, 1'b0, "reset_ch0");
    sb_push(0, 1, 8'd128, 1'b0, "reset_ch1");

    // Ramp up with acceleration on the fifth tick; channel 1 stays idle.
    bus.plus[0] = 1'b1;
    tick_begin();
    sb_push(1, 0, 8'd129, 1'b1, "ramp_t1");
    sb_push(1, 1, 8'd128, 1'b0, "indep_ch1");
    tick_end();
    tick_exp(0, 8'd130, 1'b1, "ramp_t2");
    tick_exp(0, 8'd131, 1'b1, "ramp_t3");
    tick_exp(0, 8'd132, 1'b1, "ramp_t4");
    tick_exp(0, 8'd134, 1'b1, "ramp_t5_accel");

    // Reversal restarts at STEP_MIN.
    bus.plus[0]  = 1'b0;
    bus.minus[0] = 1'b1;
    tick_exp(0, 8'd133, 1'b1, "reverse_t1");
    tick_exp(0, 8'd132, 1'b1, "reverse_t2");
    bus.minus[0] = 1'b0;
    tick_exp(0, AC ? 8'd128 : 8'd132, 1'b0, "release_132");

    // Release from 141.
    set_src(0, MODE_PAD, 8'd141, 8'd141, "pad_141");
    to_digital(0, 8'd141, "pad2dig_hold");
    tick_exp(0, AC ? 8'd137 : 8'd141, AC, "ret_t1");
    tick_exp(0, AC ? 8'd133 : 8'd141, AC, "ret_t2");
    tick_exp(0, AC ? 8'd129 : 8'd141, AC, "ret_t3");
    tick_exp(0, AC ? 8'd128 : 8'd141, 1'b0, "ret_t4_idle");

    // Both buttons held at 140: no ramp.
    set_src(0, MODE_PAD, 8'd140, 8'd140, "pad_140");
    to_digital(0, 8'd140, "pad2dig_140");
    bus.plus[0]  = 1'b1;
    bus.minus[0] = 1'b1;
    tick_exp(0, AC ? 8'd136 : 8'd140, AC, "both_held");
    bus.plus[0]  = 1'b0;
    bus.minus[0] = 1'b0;

    // Analog mode on channel 1, no strobe needed.
    set_src(1, MODE_ANA, 8'h90, 8'd16,  "ana_m112");
    set_src(1, MODE_ANA, 8'h7F, 8'd255, "ana_p127");
    set_src(1, MODE_ANA, 8'h80, 8'd0,   "ana_m128");
    set_src(1, MODE_ANA, 8'h00, 8'd128, "ana_zero");
    set_src(1, MODE_ANA, 8'h90, 8'd16,  "ana_m112_again");
    to_digital(1, 8'd16, "ana2dig_nojump");
    bus.plus[1] = 1'b1;
    tick_exp(1, 8'd17, 1'b1, "ana2dig_plus");
    step_clk();
    bus.mode[3:2] = 2'd3;
    tick_exp(1, 8'd18, 1'b1, "mode3_digital");
    bus.plus[1] = 1'b0;

    // Upper saturation: from 138, tick 28 reaches 250, tick 29 uses step 8.
    set_src(0, MODE_PAD, 8'd138, 8'd138, "pad_138");
    to_digital(0, 8'd138, "pad2dig_138");
    bus.plus[0] = 1'b1;
    repeat (27) tick();
    tick_exp(0, 8'd250, 1'b1, "sat_t28");
    tick_exp(0, 8'd255, 1'b1, "sat_t29");
    tick_exp(0, 8'd255, 1'b1, "sat_t30");
    tick_exp(0, 8'd255, 1'b1, "sat_t31");
    bus.plus[0] = 1'b0;

    // Lower saturation: from 5, tick 5 steps by 2 past zero.
    set_src(0, MODE_PAD, 8'd5, 8'd5, "pad_5");
    to_digital(0, 8'd5, "pad2dig_5");
    bus.minus[0] = 1'b1;
    tick_exp(0, 8'd4, 1'b1, "dn_t1");
    tick();
    tick();
    tick_exp(0, 8'd1, 1'b1, "dn_t4");
    tick_exp(0, 8'd0, 1'b1, "dn_t5_sat");
    tick_exp(0, 8'd0, 1'b1, "dn_t6_sat");

    // Reverse and accelerate, then reset coincident with a tick.
    bus.minus[0] = 1'b0;
    bus.plus[0]  = 1'b1;
    tick_exp(0, 8'd1, 1'b1, "pre_rst_t1");
    repeat (3) tick();
    tick_exp(0, 8'd6, 1'b1, "pre_rst_t5");
    step_clk();
    reset      = 1'b1;
    bus.strobe = 1'b1;
    sb_push(1, 0, 8'd128, 1'b0, "rst_tick_ch0");
    sb_push(1, 1, 8'd128, 1'b0, "rst_tick_ch1");
    step_clk();
    reset      = 1'b0;
    bus.strobe = 1'b0;
    sb_push(1, 0, 8'd128, 1'b0, "post_rst_hold");
    tick_exp(0, 8'd129, 1'b1, "post_rst_t1");
    tick();
    tick();
    tick_exp(0, 8'd132, 1'b1, "post_rst_t4");
    tick_exp(0, 8'd134, 1'b1, "post_rst_t5_accel");
    bus.plus[0] = 1'b0;

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      errors += sb_q.size();
      $display("FAIL drain: %0d expectations never checked, required 0", sb_q.size());
    end
    step_clk();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
